fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants and types.
//   fetch_state_t     : fetch FSM state encodings
//   FETCH_RESET_PC    : default first fetch address after reset
//   FETCH_NOP_INSTR   : addi x0,x0,0, loaded into IF/ID on reset and flush
//   FETCH_PC_STEP     : sequential PC increment
//   align_word()      : clears the byte-offset bits of a redirect target
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HOLD    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] FETCH_PC_STEP   = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register and a one-entry
// skid buffer. Keeps at most one instruction-memory request outstanding.
//   Clk, RstN                 : clock, async active-low reset
//   Stall                     : hazard-unit hold, freezes IF/ID
//   BranchTaken, NewPc        : redirect from the BRU, flushes IF/ID
//   ImemReq, ImemAddr         : one-cycle fetch request and its address
//   ImemValid, ImemRdata      : fetch response strobe and instruction word
//   IfIdValid/IfIdPc/IfIdInstr: IF/ID pipeline register
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] NewPc,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemRdata,
    output logic        IfIdValid,
    output logic [31:0] IfIdPc,
    output logic [31:0] IfIdInstr
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_instr;

    // A redirect in ISSUE cancels the request in the same cycle, so the
    // request is decoded from the registered state and gated by the
    // redirect. Gating with RstN keeps the bus quiet while held in reset.
    assign ImemReq  = RstN && (state == ST_ISSUE) && !BranchTaken;
    assign ImemAddr = pc;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state     <= ST_ISSUE;
            pc        <= RESET_PC;
            IfIdValid <= 1'b0;
            IfIdPc    <= 32'h0;
            IfIdInstr <= NOP_INSTR;
            buf_pc    <= 32'h0;
            buf_instr <= 32'h0;
        end else begin
            // IF/ID: flush wins over stall, stall wins over delivery,
            // and an unstalled cycle without delivery inserts a bubble.
            if (BranchTaken) begin
                IfIdValid <= 1'b0;
                IfIdInstr <= NOP_INSTR;
            end else if (!Stall) begin
                if (state == ST_WAIT && ImemValid) begin
                    IfIdValid <= 1'b1;
                    IfIdPc    <= pc;
                    IfIdInstr <= ImemRdata;
                end else if (state == ST_HOLD) begin
                    IfIdValid <= 1'b1;
                    IfIdPc    <= buf_pc;
                    IfIdInstr <= buf_instr;
                end else begin
                    IfIdValid <= 1'b0;
                end
            end

            unique case (state)
                ST_ISSUE: begin
                    // Responses seen here belong to nobody and are ignored.
                    if (BranchTaken) pc    <= align_word(NewPc);
                    else             state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (BranchTaken) begin
                        pc    <= align_word(NewPc);
                        // Response already here: dropped now. Otherwise it
                        // is still in flight and must be swallowed later.
                        state <= ImemValid ? ST_ISSUE : ST_DISCARD;
                    end else if (ImemValid) begin
                        if (Stall) begin
                            buf_pc    <= pc;
                            buf_instr <= ImemRdata;
                            state     <= ST_HOLD;
                        end else begin
                            pc    <= pc + FETCH_PC_STEP;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (BranchTaken) pc    <= align_word(NewPc);
                    if (ImemValid)   state <= ST_ISSUE;
                end
                ST_HOLD: begin
                    if (BranchTaken) begin
                        pc    <= align_word(NewPc);
                        state <= ST_ISSUE;
                    end else if (!Stall) begin
                        pc    <= pc + FETCH_PC_STEP;
                        state <= ST_ISSUE;
                    end
                end
                default: state <= ST_ISSUE;
            endcase
        end
    end

endmodule
